// File: rtl/mac_writeback_if.sv
// Issue and writeback handshake bundle between the MAC issuer/consumer and mac_writeback.
interface mac_writeback_if #(
  parameter int TRANS_ID_BITS = 3
);
  logic                     valid_i;
  logic                     mac_ready_o;
  logic [1:0]               op_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic [31:0]              result_o;
  logic [TRANS_ID_BITS-1:0] result_trans_id_o;
  logic                     result_valid_o;
  logic                     ready_i;

  modport master (
    output valid_i, op_i, trans_id_i, ready_i,
    input  mac_ready_o, result_o, result_trans_id_o, result_valid_o
  );

  modport slave (
    input  valid_i, op_i, trans_id_i, ready_i,
    output mac_ready_o, result_o, result_trans_id_o, result_valid_o
  );
endinterface

// File: rtl/mac_writeback.sv
// Writeback stage behind the un-stallable MAC pipeline: tracks issue tags, applies
// DOT/ACC/CLR accumulate semantics and buffers results in a credit-guarded FIFO.
module mac_writeback #(
  parameter int MAC_LATENCY   = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [31:0]   dot_i,
  output logic [31:0]   acc_o,
  mac_writeback_if.slave wb
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int LAST     = MAC_LATENCY - 1;

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(FIFO_DEPTH);
  localparam logic [PTR_BITS:0]   PTR_ONE = (PTR_BITS + 1)'(1);

  typedef enum logic [1:0] {
    OP_DOT = 2'd0,
    OP_ACC = 2'd1,
    OP_CLR = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  logic [CNT_BITS-1:0]      cnt_q;
  logic                     acc_en;
  logic                     pop;
  logic                     push;

  logic                     valid_pipe_q [MAC_LATENCY];
  op_e                      op_pipe_q    [MAC_LATENCY];
  logic [TRANS_ID_BITS-1:0] id_pipe_q    [MAC_LATENCY];

  logic [31:0]              acc_q;
  logic [31:0]              acc_d;
  logic [31:0]              acc_sum;
  logic [31:0]              exit_data;

  logic [31:0]              fifo_data_q [FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] fifo_id_q   [FIFO_DEPTH];
  logic [PTR_BITS:0]        wr_ptr_q;
  logic [PTR_BITS:0]        rd_ptr_q;

  // Credits cover both in-flight and buffered results, so the FIFO can never overflow.
  assign wb.mac_ready_o = (cnt_q < CNT_MAX);
  assign acc_en         = wb.valid_i & wb.mac_ready_o & ~flush_i;
  assign pop            = wb.result_valid_o & wb.ready_i;
  assign push           = valid_pipe_q[LAST] & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (acc_en && !pop) begin
      cnt_q <= cnt_q + CNT_ONE;
    end else if (!acc_en && pop) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < MAC_LATENCY; i++) begin
        valid_pipe_q[i] <= 1'b0;
        op_pipe_q[i]    <= OP_DOT;
        id_pipe_q[i]    <= '0;
      end
    end else begin
      valid_pipe_q[0] <= acc_en;
      op_pipe_q[0]    <= op_e'(wb.op_i);
      id_pipe_q[0]    <= wb.trans_id_i;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        valid_pipe_q[i] <= valid_pipe_q[i-1] & ~flush_i;
        op_pipe_q[i]    <= op_pipe_q[i-1];
        id_pipe_q[i]    <= id_pipe_q[i-1];
      end
    end
  end

  assign acc_sum = acc_q + dot_i;

  // The accumulator only moves when the exiting instruction is actually written back.
  always_comb begin
    exit_data = dot_i;
    acc_d     = acc_q;
    case (op_pipe_q[LAST])
      OP_ACC: begin
        exit_data = acc_sum;
        acc_d     = acc_sum;
      end
      OP_CLR: begin
        acc_d = dot_i;
      end
      default: begin
        exit_data = dot_i;
      end
    endcase
    if (!push) begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q[PTR_BITS-1:0]] <= exit_data;
        fifo_id_q[wr_ptr_q[PTR_BITS-1:0]]   <= id_pipe_q[LAST];
        wr_ptr_q                            <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign wb.result_valid_o    = (wr_ptr_q != rd_ptr_q);
  assign wb.result_o          = fifo_data_q[rd_ptr_q[PTR_BITS-1:0]];
  assign wb.result_trans_id_o = fifo_id_q[rd_ptr_q[PTR_BITS-1:0]];

endmodule

// File: tb/tb_mac_writeback.sv
// Directed scoreboard bench for mac_writeback with a 3-cycle MAC datapath stand-in.
module tb_mac_writeback;

  localparam int TID = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] dot_i;
  logic [31:0] acc_o;
  logic [31:0] issue_dot;
  logic [31:0] dot_pipe [3];

  typedef struct packed {
    logic [31:0]    data;
    logic [TID-1:0] id;
  } exp_t;

  exp_t sb [$];
  exp_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  mac_writeback_if #(.TRANS_ID_BITS(TID)) wb ();

  mac_writeback #(
    .MAC_LATENCY  (3),
    .FIFO_DEPTH   (4),
    .TRANS_ID_BITS(TID)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .dot_i  (dot_i),
    .acc_o  (acc_o),
    .wb     (wb)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the MAC datapath: operands issued in cycle T produce dot_i in T+3.
  always @(posedge clk_i) begin
    dot_pipe[0] <= issue_dot;
    dot_pipe[1] <= dot_pipe[0];
    dot_pipe[2] <= dot_pipe[1];
  end
  assign dot_i = dot_pipe[2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && wb.result_valid_o === 1'b1 && wb.ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=0x%08h id=%0d required=none",
                 wb.result_o, wb.result_trans_id_o);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("result_data", wb.result_o, mon_exp.data);
        checkOutput("result_id", 32'(wb.result_trans_id_o), 32'(mon_exp.id));
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pushExpected(input int id, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.id   = id[TID-1:0];
    sb.push_back(e);
  endtask

  // One-cycle issue with a hand-computed readiness and, if accepted, result.
  task automatic applyStimulus(input logic [1:0] op, input int id, input logic [31:0] dot,
                               input bit exp_ready, input bit push, input logic [31:0] exp_data);
    wb.valid_i    = 1'b1;
    wb.op_i       = op;
    wb.trans_id_i = id[TID-1:0];
    issue_dot     = dot;
    @(negedge clk_i);
    checkOutput("mac_ready", 32'(wb.mac_ready_o), 32'(exp_ready));
    if (push) pushExpected(id, exp_data);
    @(posedge clk_i);
    #1;
    wb.valid_i = 1'b0;
    issue_dot  = 32'hDEAD_BEEF;
  endtask

  // Issuer holds valid until the DUT offers a credit.
  task automatic issueHold(input logic [1:0] op, input int id, input logic [31:0] dot,
                           input logic [31:0] exp_data);
    bit accepted;
    accepted      = 1'b0;
    wb.valid_i    = 1'b1;
    wb.op_i       = op;
    wb.trans_id_i = id[TID-1:0];
    issue_dot     = dot;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (wb.mac_ready_o === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL issue_timeout actual=not_accepted required=accepted id=%0d", id);
    end else begin
      pushExpected(id, exp_data);
    end
    @(posedge clk_i);
    #1;
    wb.valid_i = 1'b0;
    issue_dot  = 32'hDEAD_BEEF;
  endtask

  task automatic waitDrain(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    wb.valid_i    = 1'b0;
    wb.op_i       = 2'd0;
    wb.trans_id_i = '0;
    wb.ready_i    = 1'b0;
    issue_dot     = 32'hDEAD_BEEF;
    #2 rst_i = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_result_valid", 32'(wb.result_valid_o), 32'd0);
    checkOutput("rst_result", wb.result_o, 32'd0);
    checkOutput("rst_result_id", 32'(wb.result_trans_id_o), 32'd0);
    checkOutput("rst_acc", acc_o, 32'd0);
    checkOutput("rst_mac_ready", 32'(wb.mac_ready_o), 32'd1);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    idleCycles(1);

    $display("[TB] single DOT latency");
    wb.ready_i = 1'b1;
    applyStimulus(2'd0, 5, 32'hFFFF_FF80, 1'b1, 1'b1, 32'hFFFF_FF80);
    repeat (3) @(negedge clk_i);
    checkOutput("lat_not_early", 32'(wb.result_valid_o), 32'd0);
    @(negedge clk_i);
    checkOutput("lat_on_time", 32'(wb.result_valid_o), 32'd1);
    checkOutput("dot_acc_unchanged", acc_o, 32'd0);
    idleCycles(2);

    $display("[TB] CLR/ACC/ACC back-to-back");
    applyStimulus(2'd2, 1, 32'd100, 1'b1, 1'b1, 32'd100);
    applyStimulus(2'd1, 2, -32'sd30, 1'b1, 1'b1, 32'd70);
    applyStimulus(2'd1, 3, 32'd7, 1'b1, 1'b1, 32'd77);
    idleCycles(6);
    checkOutput("acc_after_chain", acc_o, 32'd77);

    $display("[TB] back-pressure credit limit");
    wb.ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd0, i, 32'h100 + 32'(i), (i < 4), (i < 4), 32'h100 + 32'(i));
    end
    idleCycles(6);
    @(negedge clk_i);
    checkOutput("full_valid", 32'(wb.result_valid_o), 32'd1);
    checkOutput("full_head_stable", wb.result_o, 32'h100);
    checkOutput("full_head_id", 32'(wb.result_trans_id_o), 32'd0);
    checkOutput("full_not_ready", 32'(wb.mac_ready_o), 32'd0);
    @(posedge clk_i);
    #1 wb.ready_i = 1'b1;
    waitDrain(20);
    @(negedge clk_i);
    checkOutput("ready_after_drain", 32'(wb.mac_ready_o), 32'd1);
    idleCycles(1);

    $display("[TB] issue while popping from a full FIFO");
    wb.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) issueHold(2'd0, i, 32'h200 + 32'(i), 32'h200 + 32'(i));
    idleCycles(6);
    wb.ready_i = 1'b1;
    for (int i = 4; i < 8; i++) issueHold(2'd0, i, 32'h200 + 32'(i), 32'h200 + 32'(i));
    waitDrain(30);
    idleCycles(2);

    $display("[TB] accumulator wrap and reserved op");
    applyStimulus(2'd2, 6, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h7FFF_FFFF);
    applyStimulus(2'd1, 7, 32'd1, 1'b1, 1'b1, 32'h8000_0000);
    applyStimulus(2'd3, 4, 32'h55, 1'b1, 1'b1, 32'h55);
    waitDrain(20);
    idleCycles(2);
    checkOutput("acc_wrap", acc_o, 32'h8000_0000);

    $display("[TB] flush with ACCs in flight");
    applyStimulus(2'd1, 1, 32'd5, 1'b1, 1'b0, 32'd0);
    applyStimulus(2'd1, 2, 32'd6, 1'b1, 1'b0, 32'd0);
    idleCycles(1);
    flush_i       = 1'b1;
    wb.valid_i    = 1'b1;
    wb.op_i       = 2'd1;
    wb.trans_id_i = 3'd3;
    issue_dot     = 32'd9;
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    wb.valid_i = 1'b0;
    issue_dot  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    checkOutput("flush_no_valid", 32'(wb.result_valid_o), 32'd0);
    checkOutput("flush_ready", 32'(wb.mac_ready_o), 32'd1);
    idleCycles(6);
    checkOutput("flush_acc_kept", acc_o, 32'h8000_0000);
    checkOutput("flush_still_empty", 32'(wb.result_valid_o), 32'd0);

    $display("[TB] async reset mid-burst");
    wb.ready_i = 1'b0;
    applyStimulus(2'd0, 3, 32'h1234, 1'b1, 1'b0, 32'd0);
    applyStimulus(2'd0, 4, 32'h5678, 1'b1, 1'b0, 32'd0);
    idleCycles(5);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("arst_result_valid", 32'(wb.result_valid_o), 32'd0);
    checkOutput("arst_result", wb.result_o, 32'd0);
    checkOutput("arst_result_id", 32'(wb.result_trans_id_o), 32'd0);
    checkOutput("arst_acc", acc_o, 32'd0);
    checkOutput("arst_mac_ready", 32'(wb.mac_ready_o), 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    wb.ready_i = 1'b1;
    idleCycles(6);
    checkOutput("post_reset_empty", 32'(wb.result_valid_o), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
